// File: rtl/hweval_mont_harness.sv
// Campaign harness for an external Montgomery multiplier: chains ITERS products,
// folds each result into a 32-bit signature and reports pass/fail/timeout.
module hweval_mont_harness #(
    parameter int unsigned      WIDTH   = 1024,
    parameter int unsigned      ITERS   = 16,
    parameter int unsigned      TIMEOUT = 4096,
    parameter logic [WIDTH-1:0] MODULUS = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter logic [31:0]      EXP_SIG = 32'h0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         run,
    output logic                         core_start,
    output logic [WIDTH-1:0]             core_a,
    output logic [WIDTH-1:0]             core_b,
    output logic [WIDTH-1:0]             core_m,
    input  logic [WIDTH-1:0]             core_result,
    input  logic                         core_done,
    output logic                         busy,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic [$clog2(ITERS+1)-1:0]   iter_cnt,
    output logic [31:0]                  signature
);

    localparam int unsigned CNT_W  = $clog2(ITERS + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned NSLICE = WIDTH / 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [31:0]        sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               to_q, to_d;
    logic [31:0]        sig_upd;
    logic [CNT_W-1:0]   cnt_inc;

    // XOR of all 32-bit slices of a product
    function automatic logic [31:0] fold32(input logic [WIDTH-1:0] v);
        logic [31:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            acc = acc ^ v[i*32 +: 32];
        end
        return acc;
    endfunction

    assign sig_upd = {sig_q[30:0], sig_q[31]} ^ fold32(res_q);
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        start_d = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        to_d    = to_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (run) begin
                    a_d     = WIDTH'(1);
                    b_d     = WIDTH'(1);
                    sig_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    to_d    = 1'b0;
                    start_d = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tmr_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    res_d   = core_result;
                    state_d = S_UPDATE;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    fail_d  = 1'b1;
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_UPDATE: begin
                a_d   = b_q ^ res_q;
                b_d   = res_q;
                sig_d = sig_upd;
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(ITERS)) begin
                    // Resolve the verdict now so it shows two cycles after the last core_done
                    pass_d  = (sig_upd == EXP_SIG);
                    fail_d  = (sig_upd != EXP_SIG);
                    state_d = S_CHECK;
                end else begin
                    start_d = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_CHECK: begin
                pass_d  = (sig_q == EXP_SIG);
                fail_d  = (sig_q != EXP_SIG);
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT) ||
                 (state_d == S_UPDATE) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            a_q     <= WIDTH'(1);
            b_q     <= WIDTH'(1);
            res_q   <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            to_q    <= to_d;
        end
    end

    assign core_start = start_q;
    assign core_a     = a_q;
    assign core_b     = b_q;
    assign core_m     = MODULUS;
    assign busy       = busy_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign timeout    = to_q;
    assign iter_cnt   = cnt_q;
    assign signature  = sig_q;

endmodule
